mem_wait_responder: RTL
=======================

# mem_wait_responder

Memory-side responder for the multicycle CPU's data/instruction bus. It accepts single-word read and write requests from an initiator, holds them for a configurable number of wait states, then completes them with a one-cycle acknowledge. It serves as the slow-memory counterpart that the control unit handshakes with in place of the zero-wait memory, and it flags misaligned or out-of-range accesses instead of performing them.

## Interface
- ADDR_W, 8: byte-address width of the backing store; capacity is 2^ADDR_W bytes.
- LATENCY, 2: cycles from request acceptance to `ack`; legal range 1..15.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with `req`.
- addr  input  32  byte address; sampled with `req`.
- wdata  input  32  write data; sampled with `req`.
- rdata  output  32  read data; valid while `ack`=1, held until the next successful read.
- ack  output  1  one-cycle completion pulse.
- addr_err  output  1  qualifies `ack`: 1 = access rejected, no effect on storage.
- busy  output  1  1 while a request is in flight (WAIT or RESP).

## Operation
- Storage: byte array of 2^ADDR_W bytes, big-endian; word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}. Contents are not cleared by reset.
- The FSM has three states: IDLE, WAIT, and RESP.
- IDLE:
  - If `req`=1, latch `we`, `addr`, and `wdata`.
  - Error check: `addr[1:0]`≠0, or `addr[31:ADDR_W]`≠0 → error request → go to RESP directly, regardless of LATENCY.
  - Otherwise load counter = LATENCY−1. Go to RESP if LATENCY=1, else go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter is 1, go to RESP.
- Access commit happens on the edge entering RESP, for valid requests only:
  - Write: store 4 bytes.
  - Read: register the word into `rdata`.
- RESP:
  - `ack`=1 for exactly one cycle. `addr_err`=1 only for an error request, otherwise 0.
  - Next state is always IDLE. `req` is ignored in RESP; the initiator must re-present it in IDLE.
- `req`, `we`, `addr`, and `wdata` changes during WAIT/RESP have no effect (latched copy used).
- On error requests:
  - `rdata` keeps its previous value.
  - Storage is untouched.
- Counter width: 4 bits. No wrap occurs, since the counter only counts down from ≤14 to 1.

## Timing
- Reset values: `rdata`=0, `ack`=0, `addr_err`=0, `busy`=0, state=IDLE, counter=0.
- Latency:
  - Valid request sampled at edge k → `ack` high during the cycle after edge k+LATENCY−1, i.e. visible in cycle k+LATENCY.
  - Error request sampled at edge k → `ack` high in cycle k+1.
- Throughput: back-to-back valid requests complete every LATENCY+1 cycles, because of the RESP dead cycle.
- `busy` rises the cycle after acceptance and falls in the cycle following RESP. `busy` and `ack` are high together in RESP.
- Reset asserted mid-request (WAIT or RESP) takes effect at the next edge:
  - The request is aborted and a pending write is not committed.
  - The outputs return to their reset values.
- `req`=1 on the same edge that reset is released is ignored; the first request can be accepted at the following edge.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 (LATENCY=2) → `ack` pulses exactly once, 2 cycles after acceptance, with `addr_err`=0. Then read 0x10 → `rdata`=0xDEADBEEF with `ack`.
- Byte order: write 0x11223344 to 0x20, then read 0x20 → 0x11223344. Backdoor check shows mem[0x20]=0x11 and mem[0x23]=0x44.
- Misaligned read of 0x21 and out-of-range write to 0x100 (ADDR_W=8) → each gets `ack` 1 cycle after acceptance with `addr_err`=1. `rdata` is unchanged and storage is unchanged.
- Hold `req`=1 continuously with alternating writes (LATENCY=3) → `ack` every 4 cycles. Changing `addr` during WAIT has no effect on the target word.
- Pull `reset` low during WAIT of a write of 0xCAFEF00D to 0x40 → no `ack`, outputs go to 0, and a later read of 0x40 returns the prior contents.
- LATENCY=1 sweep: a read accepted at edge k gives `ack` at cycle k+1 and `busy`=1 only in that cycle.

Source files
------------

// File: rtl/mem_wait_responder.sv
// Slow-memory bus responder: accepts one word request, waits LATENCY cycles, then acks.
// Misaligned or out-of-range accesses are acknowledged with addr_err and have no effect.
module mem_wait_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        addr_err,
    output logic        busy
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [7:0]          mem [Depth];

    logic                req_err;
    logic                commit;
    logic                cmt_we;
    logic [ADDR_W-1:0]   cmt_addr;
    logic [31:0]         cmt_wdata;
    logic [ADDR_W-1:0]   b0, b1, b2, b3;

    assign req_err = (addr[1:0] != 2'b00) || ((addr >> ADDR_W) != 32'd0);

    // Big-endian byte lanes of the word being committed
    assign b0 = {cmt_addr[ADDR_W-1:2], 2'd0};
    assign b1 = {cmt_addr[ADDR_W-1:2], 2'd1};
    assign b2 = {cmt_addr[ADDR_W-1:2], 2'd2};
    assign b3 = {cmt_addr[ADDR_W-1:2], 2'd3};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && commit && cmt_we) begin
            mem[b0] <= cmt_wdata[31:24];
            mem[b1] <= cmt_wdata[23:16];
            mem[b2] <= cmt_wdata[15:8];
            mem[b3] <= cmt_wdata[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        commit    = 1'b0;
        cmt_we    = we_q;
        cmt_addr  = addr_q;
        cmt_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[ADDR_W-1:0];
                    wdata_d = wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else begin
                        cnt_d = CntInit;
                        if (LATENCY == 1) begin
                            // Single-cycle latency commits straight from the bus inputs
                            state_d   = StResp;
                            commit    = 1'b1;
                            cmt_we    = we;
                            cmt_addr  = addr[ADDR_W-1:0];
                            cmt_wdata = wdata;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        rdata_d = rdata_q;
        if (commit && !cmt_we) begin
            rdata_d = {mem[b0], mem[b1], mem[b2], mem[b3]};
        end
    end

    always_comb begin
        ack      = (state_q == StResp);
        addr_err = (state_q == StResp) && err_q;
        busy     = (state_q != StIdle);
        rdata    = rdata_q;
    end

endmodule
